pal_macro_fabric: RTL and testbench
===================================

Name: pal_macro_fabric

Overview:
- Second-generation parametrised PAL/GAL fabric with a programmable AND plane, a programmable OR plane and per-output macrocells. Each macrocell has combinational or registered mode, output inversion, and feedback into the AND plane.
- Configuration is loaded serially into a double-buffered shadow chain. The chain has a bit counter, overrun detection, commit/error signalling and a daisy-chain output.
- Sits under the top-level wrapper in place of the first-generation PAL.

Parameters:
- N, 8, number of primary inputs.
- M, 4, number of outputs/macrocells.
- P, 16, number of product terms.
- CFG_LEN, derived = 2*(N+M)*P + M*P + 2*M (456 at defaults), total config bits; not overridable.

Ports:
- CLK  in  1  clock
- RES  in  1  asynchronous active-high reset
- EN  in  1  fabric enable; low freezes macrocell registers
- CFG_IN  in  1  serial config data
- CFG_SHIFT  in  1  shift CFG_IN into the shadow chain this cycle
- CFG_APPLY  in  1  request commit of shadow to active config
- CFG_OUT  out  1  shadow[CFG_LEN-1], for daisy chaining
- CFG_DONE  out  1  one-cycle pulse: commit succeeded
- CFG_ERR  out  1  one-cycle pulse: commit rejected
- CFG_VALID  out  1  an active config is loaded
- INPUT_VARS  in  N  primary inputs
- OUTPUT_VALS  out  M  fabric outputs

Behaviour:
- One clock CLK. Reset RES is asynchronous, active-high.
- Reset clears all registers:
  - shadow and active config = 0, counter = 0, loader state = IDLE;
  - macrocell regs = 0;
  - CFG_VALID/CFG_DONE/CFG_ERR = 0, CFG_OUT = 0, OUTPUT_VALS = 0.
- Reset mid-load or mid-operation discards everything; the fabric must be reloaded.
- Shift: when CFG_SHIFT=1 and CFG_APPLY=0, shadow <= {shadow[CFG_LEN-2:0], CFG_IN}. The last bit shifted lands at index 0.
- Counter saturates at CFG_LEN.
- Loader FSM:
  - IDLE (cnt=0) -> LOADING on a shift.
  - LOADING -> FULL when cnt reaches CFG_LEN.
  - FULL -> OVERRUN on any further shift. OVERRUN is sticky; the shadow keeps shifting (daisy-chain pass-through).
- Apply: CFG_APPLY=1 has priority; a simultaneous CFG_SHIFT is ignored that cycle.
  - In FULL: active <= shadow; CFG_DONE pulses the next cycle; CFG_VALID <= 1; macrocell regs cleared to 0 in the same edge.
  - In IDLE/LOADING/OVERRUN: active is unchanged; CFG_ERR pulses the next cycle; CFG_VALID is unchanged.
  - Both cases: counter <= 0, state <= IDLE, shadow contents retained.
- The active config is stable while a new shadow is shifted; the fabric keeps running.
- Config map (indices into active):
  - [2m] = REG_EN for output m; [2m+1] = INV for output m.
  - [2M + m*P + p] = OR-plane connection of term p to output m.
  - [2M + M*P + p*2*(N+M) + 2k] = true literal k in term p; +1 = complemented literal k.
  - Literal k<N is INPUT_VARS[k]; literal k>=N is FB[k-N].
- Product term p = AND of selected literals. A term with no literal selected = 0.
- Sum S_m = OR of connected terms; no terms connected = 0.
- Macrocell m:
  - register Q_m <= S_m on CLK when CFG_VALID && EN; otherwise holds.
  - FB[m] = Q_m always (no combinational loops).
  - OUTPUT_VALS[m] = CFG_VALID ? ((REG_EN ? Q_m : S_m) ^ INV) : 0.
- Latency: combinational mode is input-to-output in the same cycle; registered mode is one cycle.

Decomposition:
- Package pal_macro_pkg:
  - cfg_len(N,M,P) function;
  - field offset functions (mc_bit, or_bit, and_bit);
  - loader state enum {IDLE, LOADING, FULL, OVERRUN}.
- Sub-module pal_macrocell: per-output register, mode mux, inversion and enable gating; instantiated M times.
- Loader, counter and the AND/OR planes stay in the top.

Test Plan (N=4, M=2, P=4, CFG_LEN=60):
- Reset, then shift 60 bits making term0 = in0&in1 -> out0 combinational, then APPLY -> CFG_DONE pulses once, CFG_VALID=1. in=4'b0011 -> out0=1 same cycle; in=4'b0001 -> out0=0.
- APPLY after only 59 shifts -> CFG_ERR pulse, CFG_VALID stays 0, OUTPUT_VALS=0. A following full 60-bit load + APPLY -> CFG_DONE.
- Shift 61 bits then APPLY -> CFG_ERR (overrun). CFG_OUT shows the bit shifted 60 cycles earlier.
- Registered toggle: term0 = !FB0 -> out0 with REG_EN=1. After apply, out0 sequence 1,0,1,0 per CLK with EN=1. Holding EN=0 freezes it.
- While running config A, shift config B (out0 inverted): outputs follow A throughout the shift and switch to B the cycle after APPLY. CFG_SHIFT and CFG_APPLY high together -> shift ignored.
- Assert RES mid-load and while active -> all outputs, CFG_VALID and counter 0 immediately (asynchronous). An APPLY right after reset -> CFG_ERR.

Source files
------------

// File: rtl/pal_macro_pkg.sv
// Shared types and config-map helpers for the PAL/GAL macrocell fabric.
package pal_macro_pkg;

    // Serial config loader states.
    typedef enum logic [1:0] {
        StIdle,
        StLoading,
        StFull,
        StOverrun
    } load_state_e;

    // Total configuration length for a fabric of n inputs, m outputs and p product terms.
    function automatic int unsigned cfg_len(input int unsigned n, input int unsigned m,
                                            input int unsigned p);
        return 2 * (n + m) * p + m * p + 2 * m;
    endfunction

    // Macrocell control bit: inv=0 selects REG_EN, inv=1 selects INV for output m.
    function automatic int unsigned mc_bit(input int unsigned m, input int unsigned inv);
        return 2 * m + inv;
    endfunction

    // OR-plane bit connecting term p to output m.
    function automatic int unsigned or_bit(input int unsigned nm, input int unsigned np,
                                           input int unsigned m, input int unsigned p);
        return 2 * nm + m * np + p;
    endfunction

    // AND-plane bit selecting literal k of term p; neg=1 selects the complemented literal.
    function automatic int unsigned and_bit(input int unsigned nn, input int unsigned nm,
                                            input int unsigned np, input int unsigned p,
                                            input int unsigned k, input int unsigned neg);
        return 2 * nm + nm * np + p * 2 * (nn + nm) + 2 * k + neg;
    endfunction

endpackage

// File: rtl/pal_macrocell.sv
// One output macrocell: state register, combinational/registered select, inversion and
// gating of the output until a configuration has been committed.
module pal_macrocell
    import pal_macro_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic valid_i,
    input  logic sum_i,
    input  logic reg_en_i,
    input  logic inv_i,
    output logic q_o,
    output logic out_o
);

    logic q_q;

    // Macrocell register: cleared on a successful commit, otherwise loads the sum when running.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= 1'b0;
        end else if (clr_i) begin
            q_q <= 1'b0;
        end else if (valid_i && en_i) begin
            q_q <= sum_i;
        end
    end

    // Feedback always comes from the register, so the planes never form a combinational loop.
    always_comb begin
        q_o   = q_q;
        out_o = 1'b0;
        if (valid_i) begin
            out_o = (reg_en_i ? q_q : sum_i) ^ inv_i;
        end
    end

endmodule

// File: rtl/pal_macro_fabric.sv
// Parametrised PAL/GAL fabric: programmable AND and OR planes, M macrocells with feedback,
// and a double-buffered serial configuration chain with commit/error signalling.
module pal_macro_fabric
    import pal_macro_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4,
    parameter int unsigned P = 16
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         EN,
    input  logic         CFG_IN,
    input  logic         CFG_SHIFT,
    input  logic         CFG_APPLY,
    output logic         CFG_OUT,
    output logic         CFG_DONE,
    output logic         CFG_ERR,
    output logic         CFG_VALID,
    input  logic [N-1:0] INPUT_VARS,
    output logic [M-1:0] OUTPUT_VALS
);

    localparam int unsigned CFG_LEN = cfg_len(N, M, P);
    localparam int unsigned CNT_W   = $clog2(CFG_LEN + 1);
    localparam int unsigned L       = N + M;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CFG_LEN);

    logic [CFG_LEN-1:0] shadow_q;
    logic [CFG_LEN-1:0] active_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    load_state_e        state_q;
    logic               done_q;
    logic               err_q;
    logic               valid_q;
    logic               commit;

    logic [M-1:0] fb;
    logic [L-1:0] lits;
    logic [P-1:0] terms;
    logic [M-1:0] sums;

    // Commit is only legal once exactly CFG_LEN bits have been shifted in.
    always_comb begin
        commit  = CFG_APPLY && (state_q == StFull);
        cnt_inc = cnt_q + 1'b1;
    end

    // Loader FSM: shift chain, saturating bit counter, commit/reject and status pulses.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            state_q  <= StIdle;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (CFG_APPLY) begin
                // Apply wins over a simultaneous shift; shadow contents are kept either way.
                cnt_q   <= '0;
                state_q <= StIdle;
                if (commit) begin
                    active_q <= shadow_q;
                    valid_q  <= 1'b1;
                    done_q   <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (CFG_SHIFT) begin
                shadow_q <= {shadow_q[CFG_LEN-2:0], CFG_IN};
                if (cnt_q != CntMax) begin
                    cnt_q <= cnt_inc;
                end
                unique case (state_q)
                    StIdle:    state_q <= (cnt_inc == CntMax) ? StFull : StLoading;
                    StLoading: if (cnt_inc == CntMax) state_q <= StFull;
                    StFull:    state_q <= StOverrun;
                    StOverrun: state_q <= StOverrun;
                endcase
            end
        end
    end

    assign CFG_OUT   = shadow_q[CFG_LEN-1];
    assign CFG_DONE  = done_q;
    assign CFG_ERR   = err_q;
    assign CFG_VALID = valid_q;

    // Literal vector: primary inputs first, then macrocell feedback.
    assign lits = {fb, INPUT_VARS};

    // AND plane: a term with no literal selected is forced to 0 rather than 1.
    for (genvar p = 0; p < P; p++) begin : g_term
        logic [L-1:0] pos_sel;
        logic [L-1:0] neg_sel;
        for (genvar k = 0; k < L; k++) begin : g_lit
            localparam int unsigned PosIdx = and_bit(N, M, P, p, k, 0);
            localparam int unsigned NegIdx = and_bit(N, M, P, p, k, 1);
            assign pos_sel[k] = active_q[PosIdx];
            assign neg_sel[k] = active_q[NegIdx];
        end
        assign terms[p] = (|(pos_sel | neg_sel)) & ~(|(pos_sel & ~lits))
                          & ~(|(neg_sel & lits));
    end

    // OR plane and macrocells.
    for (genvar m = 0; m < M; m++) begin : g_out
        localparam int unsigned OrIdx  = or_bit(M, P, m, 0);
        localparam int unsigned RegIdx = mc_bit(m, 0);
        localparam int unsigned InvIdx = mc_bit(m, 1);
        logic [P-1:0] or_sel;

        assign or_sel  = active_q[OrIdx +: P];
        assign sums[m] = |(or_sel & terms);

        pal_macrocell u_mc (
            .clk_i    (CLK),
            .rst_i    (RES),
            .clr_i    (commit),
            .en_i     (EN),
            .valid_i  (valid_q),
            .sum_i    (sums[m]),
            .reg_en_i (active_q[RegIdx]),
            .inv_i    (active_q[InvIdx]),
            .q_o      (fb[m]),
            .out_o    (OUTPUT_VALS[m])
        );
    end

endmodule

// File: tb/tb_pal_macro_fabric.sv
// Self-checking bench for pal_macro_fabric at N=4, M=2, P=4 (60 config bits).
module tb_pal_macro_fabric;

    localparam int N   = 4;
    localparam int M   = 2;
    localparam int P   = 4;
    localparam int LEN = 2 * (N + M) * P + M * P + 2 * M;

    logic         CLK = 1'b0;
    logic         RES = 1'b1;
    logic         EN = 1'b1;
    logic         CFG_IN = 1'b0;
    logic         CFG_SHIFT = 1'b0;
    logic         CFG_APPLY = 1'b0;
    logic         CFG_OUT;
    logic         CFG_DONE;
    logic         CFG_ERR;
    logic         CFG_VALID;
    logic [N-1:0] INPUT_VARS = '0;
    logic [M-1:0] OUTPUT_VALS;

    int n_chk = 0;
    int n_err = 0;

    string sb_tag[$];
    int    sb_exp[$];

    logic [LEN-1:0] cfg_a;
    logic [LEN-1:0] cfg_b;
    logic [LEN-1:0] cfg_t;
    logic [LEN:0]   pat;

    pal_macro_fabric #(
        .N (N),
        .M (M),
        .P (P)
    ) dut (
        .CLK         (CLK),
        .RES         (RES),
        .EN          (EN),
        .CFG_IN      (CFG_IN),
        .CFG_SHIFT   (CFG_SHIFT),
        .CFG_APPLY   (CFG_APPLY),
        .CFG_OUT     (CFG_OUT),
        .CFG_DONE    (CFG_DONE),
        .CFG_ERR     (CFG_ERR),
        .CFG_VALID   (CFG_VALID),
        .INPUT_VARS  (INPUT_VARS),
        .OUTPUT_VALS (OUTPUT_VALS)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    function automatic int idx_mc(input int m, input int inv);
        return 2 * m + inv;
    endfunction

    function automatic int idx_or(input int m, input int p);
        return 2 * M + m * P + p;
    endfunction

    function automatic int idx_and(input int p, input int k, input int neg);
        return 2 * M + M * P + p * 2 * (N + M) + 2 * k + neg;
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        sb_tag.push_back(tag);
        sb_exp.push_back(exp);
    endtask

    // Compare every pending expectation against the matching DUT output.
    task automatic sb_drain();
        string tag;
        int    exp;
        int    obs;
        while (sb_tag.size() > 0) begin
            tag = sb_tag.pop_front();
            exp = sb_exp.pop_front();
            if (tag == "out")         obs = int'(OUTPUT_VALS);
            else if (tag == "done")   obs = int'(CFG_DONE);
            else if (tag == "err")    obs = int'(CFG_ERR);
            else if (tag == "valid")  obs = int'(CFG_VALID);
            else if (tag == "cfgout") obs = int'(CFG_OUT);
            else                      obs = -1;
            check_val(tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic shift1(input logic b);
        CFG_SHIFT = 1'b1;
        CFG_IN    = b;
        step();
        CFG_SHIFT = 1'b0;
    endtask

    // Shift the low n bits of cfg, MSB first, so bit 0 is the last one in.
    task automatic load_bits(input logic [LEN-1:0] cfg, input int n);
        for (int i = n - 1; i >= 0; i--) shift1(cfg[i]);
    endtask

    // Pulse APPLY for one cycle, check the status pulse and that it lasts one cycle.
    task automatic apply_expect(input int ok);
        CFG_APPLY = 1'b1;
        step();
        CFG_APPLY = 1'b0;
        sb_push("done", ok);
        sb_push("err", 1 - ok);
        sb_drain();
        step();
        sb_push("done", 0);
        sb_push("err", 0);
        sb_drain();
    endtask

    task automatic set_in_expect(input logic [N-1:0] v, input int exp_out);
        INPUT_VARS = v;
        #1;
        sb_push("out", exp_out);
        sb_drain();
    endtask

    // Asynchronous reset pulse entirely between clock edges.
    task automatic reset_async();
        #2;
        RES = 1'b1;
        #1;
        sb_push("valid", 0);
        sb_push("out", 0);
        sb_push("cfgout", 0);
        sb_push("done", 0);
        sb_push("err", 0);
        sb_drain();
        #1;
        RES = 1'b0;
        step();
    endtask

    initial begin
        // A: term0 = in0 & in1 -> out0, combinational. Bit 59 set on unused term3 as a marker.
        cfg_a = '0;
        cfg_a[idx_and(0, 0, 0)] = 1'b1;
        cfg_a[idx_and(0, 1, 0)] = 1'b1;
        cfg_a[idx_or(0, 0)]     = 1'b1;
        cfg_a[idx_and(3, 5, 1)] = 1'b1;
        cfg_b = cfg_a;
        cfg_b[idx_mc(0, 1)] = 1'b1;
        // T: term0 = !FB0 -> out0, registered.
        cfg_t = '0;
        cfg_t[idx_mc(0, 0)]     = 1'b1;
        cfg_t[idx_and(0, N, 1)] = 1'b1;
        cfg_t[idx_or(0, 0)]     = 1'b1;

        // Reset state.
        step();
        RES = 1'b0;
        #1;
        sb_push("valid", 0);
        sb_push("out", 0);
        sb_push("done", 0);
        sb_push("err", 0);
        sb_push("cfgout", 0);
        sb_drain();

        // Full load of A and combinational evaluation.
        load_bits(cfg_a, LEN);
        sb_push("cfgout", 1);
        sb_push("valid", 0);
        sb_push("out", 0);
        sb_drain();
        apply_expect(1);
        sb_push("valid", 1);
        sb_drain();
        set_in_expect(4'b0011, 1);
        set_in_expect(4'b0001, 0);
        set_in_expect(4'b0010, 0);
        set_in_expect(4'b1111, 1);

        // Short load (59 bits) is rejected; a following full load commits.
        reset_async();
        load_bits(cfg_a, LEN - 1);
        apply_expect(0);
        sb_push("valid", 0);
        sb_drain();
        set_in_expect(4'b0011, 0);
        load_bits(cfg_a, LEN);
        apply_expect(1);
        set_in_expect(4'b0011, 1);

        // Overrun: 61 shifts while A runs; first bit appears at CFG_OUT after 60 shifts.
        pat = {$urandom(), $urandom()};
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        for (int j = 0; j < LEN; j++) shift1(pat[j]);
        sb_push("cfgout", 1);
        sb_drain();
        shift1(pat[LEN]);
        sb_push("cfgout", 0);
        sb_drain();
        apply_expect(0);
        sb_push("valid", 1);
        sb_drain();
        set_in_expect(4'b0011, 1);

        // Shift + apply together in FULL: commit happens, shift is ignored.
        load_bits(cfg_a, LEN);
        CFG_SHIFT = 1'b1;
        CFG_APPLY = 1'b1;
        CFG_IN    = 1'b0;
        step();
        CFG_SHIFT = 1'b0;
        CFG_APPLY = 1'b0;
        sb_push("done", 1);
        sb_push("cfgout", 1);
        sb_drain();
        step();

        // Shift B while A runs; outputs follow A until the cycle after APPLY.
        for (int i = LEN - 1; i >= 0; i--) begin
            INPUT_VARS = (i % 2 == 0) ? 4'b0011 : 4'b0001;
            shift1(cfg_b[i]);
            if (i % 15 == 0) begin
                sb_push("out", (i % 2 == 0) ? 1 : 0);
                sb_drain();
            end
        end
        set_in_expect(4'b0011, 1);
        apply_expect(1);
        set_in_expect(4'b0011, 0);
        set_in_expect(4'b0001, 1);

        // Registered toggle with EN gating.
        load_bits(cfg_t, LEN);
        EN = 1'b0;
        apply_expect(1);
        sb_push("out", 0);
        sb_drain();
        EN = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            sb_push("out", (c % 2 == 0) ? 1 : 0);
            sb_drain();
        end
        EN = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            sb_push("out", 0);
            sb_drain();
        end
        EN = 1'b1;
        step();
        sb_push("out", 1);
        sb_drain();

        // Reset mid-load discards the counter: 30 + 30 bits across a reset is not a full load.
        load_bits(cfg_a, 30);
        reset_async();
        load_bits(cfg_a, 30);
        apply_expect(0);

        // Reset while active clears outputs at once; APPLY afterwards is rejected.
        load_bits(cfg_a, LEN);
        apply_expect(1);
        set_in_expect(4'b0011, 1);
        reset_async();
        apply_expect(0);
        sb_push("valid", 0);
        sb_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
